hack_wb_loader: RTL
===================

// Module: hack_wb_loader
// PURPOSE
//  Wishbone classic responder for the Caravel management core; the target end of the wbs_* bus at the user wrapper.
//  Gives firmware a small register file to hold the Hack SoC in reset and to stream 16-bit words into the program ROM.
//  Streamed words pass through a FIFO, then drain over a valid/ready write port into the ROM/RAM loader.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  bus address of register 0; wbs_adr_i[31:4] must equal BASE_ADDR[31:4]
//  FIFO_DEPTH  4              load FIFO entries, power of 2, >=2
//  ADDR_W      15             loader address width (Hack ROM is 32K words)
// PORTS
//  wb_clk_i       in   1   single clock for bus and loader side
//  wb_rst_n_i     in   1   asynchronous, active-low reset
//  wbs_cyc_i      in   1   bus cycle
//  wbs_stb_i      in   1   strobe
//  wbs_we_i       in   1   1 = write
//  wbs_sel_i      in   4   byte selects; only sel[1:0] are used for 16-bit fields
//  wbs_adr_i      in   32  byte address
//  wbs_dat_i      in   32  write data
//  wbs_dat_o      out  32  read data, valid while wbs_ack_o=1, otherwise 0
//  wbs_ack_o      out  1   single-cycle acknowledge
//  soc_reset_o    out  1   hold Hack SoC in reset (CTRL[0])
//  load_mode_o    out  1   loader owns ROM port (CTRL[1])
//  ld_valid_o     out  1   loader write request
//  ld_addr_o      out  15  loader word address
//  ld_data_o      out  16  loader word data
//  ld_ready_i     in   1   loader accepts when ld_valid_o & ld_ready_i
// BEHAVIOUR
//  Reset: wbs_ack_o=0, wbs_dat_o=0, soc_reset_o=1, load_mode_o=0, ld_valid_o=0, ld_addr_o=0, ld_data_o=0.
//   Reset also sets FIFO empty, ADDR=0, OVF=0.
//  Register map (word offsets):
//   0x0 CTRL   RW [0]=soc_reset [1]=load_mode
//   0x4 STATUS RO [3:0]=fifo level [4]=full [5]=empty [6]=busy [7]=OVF sticky
//              busy = !empty | ld_valid_o
//   0x8 ADDR   RW [14:0]=next load address
//   0xC DATA   WO push {ADDR,wbs_dat_i[15:0]} into FIFO, then ADDR <= ADDR+1 (wraps 7FFF->0000)
//  Handshake:
//   - Request = cyc&stb&addr-match&!ack. wbs_ack_o asserts the cycle after the request and stays high exactly 1 cycle.
//   - No back-to-back acks: a request still held in the ack cycle is not re-acked.
//   - Unmatched addresses are ignored (no ack).
//   - DATA write with FIFO full: ack is withheld until a slot frees; the push and ack occur in the same cycle.
//   - DATA write while load_mode_o=0: acked but discarded, and OVF is set.
//  Byte lanes: a register field updates only if sel[0] (bits 7:0) and sel[1] (bits 15:8) are set for that field.
//   DATA push requires sel[1:0]=2'b11; otherwise the write is acked, nothing is pushed and ADDR is unchanged.
//  Reads of DATA and of unused bits return 0. Writes to STATUS: OVF is write-1-to-clear, all other bits ignored.
//  Drain: FIFO head appears on ld_addr_o/ld_data_o with ld_valid_o registered.
//   - Pop on ld_valid_o & ld_ready_i; the next entry is presented the following cycle.
//   - Sustained throughput is 1 word/cycle.
//   - ld_valid_o, ld_addr_o and ld_data_o are held stable while ld_valid_o=1 and ld_ready_i=0.
//  Simultaneous push+pop when full: allowed, and level is unchanged.
//  Clearing load_mode_o flushes the FIFO on the next edge and drops ld_valid_o. Any in-flight unaccepted word is lost.
//  Reset mid-transfer: all state returns to reset values immediately (async); a pending bus cycle gets no ack.
// CONFIGURATION
//  WB_LOADER_READBACK_EN defined:
//   - Adds port rb_data_i[15:0] and readable register 0x10 RDATA.
//   - A read of RDATA returns rb_data_i sampled at the request cycle, with ack latency unchanged.
//   - ld_addr_o drives ADDR whenever ld_valid_o=0 so firmware can verify the ROM.
//  Not defined: no rb_data_i port; 0x10 is unmatched (no ack); ld_addr_o holds the last popped address when idle.
// TESTING
//  Reset release -> soc_reset_o=1, wbs_ack_o=0, STATUS read = 32'h0000_0020.
//  Write CTRL=3, ADDR=0x7FFE, DATA 0xAAAA/0xBBBB/0xCCCC, ld_ready_i=1
//   -> loader sees (7FFE,AAAA), (7FFF,BBBB), (0000,CCCC) in order; ADDR reads 0x0001.
//  ld_ready_i=0, push 5 words with FIFO_DEPTH=4 -> 4 acks, 5th ack withheld.
//   Raise ld_ready_i -> 5th ack arrives; all 5 words drain in order.
//  load_mode=0, write DATA -> ack, ld_valid_o stays 0, STATUS[7]=1; write STATUS=0x80 -> STATUS[7]=0.
//  Write DATA with sel=4'b0001 -> ack, FIFO level and ADDR unchanged.
//   Read from BASE_ADDR+0x20 -> no ack for 16 cycles.
//  Assert wb_rst_n_i low with 3 queued words and ld_valid_o=1
//   -> ld_valid_o=0 same cycle; after release STATUS[5]=1 and CTRL=1.

Source files
------------

// File: rtl/hack_wb_loader.sv
// Wishbone register block that holds the Hack SoC in reset and streams 16-bit words into its ROM
// through a small FIFO. Define WB_LOADER_READBACK_EN to add the RDATA readback register.
module hack_wb_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              soc_reset_o,
    output logic              load_mode_o,
`ifdef WB_LOADER_READBACK_EN
    input  logic [15:0]       rb_data_i,
`endif
    output logic              ld_valid_o,
    output logic [ADDR_W-1:0] ld_addr_o,
    output logic [15:0]       ld_data_o,
    input  logic              ld_ready_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = ADDR_W + 16;

    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ld_valid_q, ld_valid_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [15:0]       ld_data_q, ld_data_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

    logic              hit_main, hit_rb, req, data_wr, push_ok, stall, push, pop, full, empty;
    logic              flush;
    logic [1:0]        reg_idx;
    logic [ENT_W-1:0]  push_entry, head_entry;
    logic [31:0]       status, count_ext;
    logic              unused_bits;

    assign hit_main = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
`ifdef WB_LOADER_READBACK_EN
    localparam logic [31:0] RbAddr = BASE_ADDR + 32'h10;
    assign hit_rb = (wbs_adr_i[31:2] == RbAddr[31:2]);
`else
    assign hit_rb = 1'b0;
`endif
    assign reg_idx = wbs_adr_i[3:2];
    assign req     = wbs_cyc_i & wbs_stb_i & (hit_main | hit_rb) & ~ack_q;

    assign pop     = ld_valid_q & ld_ready_i;
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign data_wr = req & hit_main & wbs_we_i & (reg_idx == 2'd3);
    assign push_ok = data_wr & (wbs_sel_i[1:0] == 2'b11) & ctrl_q[1];
    // A full FIFO only blocks the push if the head is not leaving on this same edge.
    assign stall   = push_ok & full & ~pop;
    assign push    = push_ok & ~stall;
    assign ack_d   = req & ~stall;

    assign push_entry = {addr_q, wbs_dat_i[15:0]};
    assign count_ext  = 32'(count_q);

    always_comb begin
        status    = '0;
        status[3:0] = count_ext[3:0];
        status[4] = full;
        status[5] = empty;
        status[6] = ~empty | ld_valid_q;
        status[7] = ovf_q;
    end

    // Register file: writes and read capture happen on the edge that raises ack.
    always_comb begin
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        rdata_d = '0;
        if (ack_d) begin
            if (hit_main) begin
                case (reg_idx)
                    2'd0: begin
                        if (wbs_we_i && wbs_sel_i[0]) ctrl_d = wbs_dat_i[1:0];
                        if (!wbs_we_i) rdata_d = {30'h0, ctrl_q};
                    end
                    2'd1: begin
                        if (wbs_we_i && wbs_sel_i[0] && wbs_dat_i[7]) ovf_d = 1'b0;
                        if (!wbs_we_i) rdata_d = status;
                    end
                    2'd2: begin
                        if (wbs_we_i && (wbs_sel_i[1:0] == 2'b11)) begin
                            addr_d = wbs_dat_i[ADDR_W-1:0];
                        end
                        if (!wbs_we_i) rdata_d = 32'(addr_q);
                    end
                    default: begin
                        if (wbs_we_i && !ctrl_q[1]) ovf_d = 1'b1;
                        if (push) addr_d = addr_q + ADDR_W'(1);
                    end
                endcase
            end
`ifdef WB_LOADER_READBACK_EN
            else if (hit_rb && !wbs_we_i) begin
                rdata_d = {16'h0, rb_data_i};
            end
`endif
        end
    end

    // Leaving load mode empties the FIFO on the same edge that clears CTRL[1].
    assign flush = ~ctrl_d[1];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ld_valid_d = ld_valid_q;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;
        head_entry = '0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ld_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
            ld_valid_d = (count_d != '0);
            // New head comes from the incoming word when nothing older remains in the FIFO.
            if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
                head_entry = push_entry;
            end else begin
                head_entry = mem_q[rd_ptr_d];
            end
            if ((count_d != '0) && (pop || !ld_valid_q)) begin
                ld_addr_d = head_entry[ENT_W-1:16];
                ld_data_d = head_entry[15:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= 2'b01;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdata_q;
    assign soc_reset_o = ctrl_q[0];
    assign load_mode_o = ctrl_q[1];
    assign ld_valid_o  = ld_valid_q;
    assign ld_data_o   = ld_data_q;
`ifdef WB_LOADER_READBACK_EN
    assign ld_addr_o   = ld_valid_q ? ld_addr_q : addr_q;
`else
    assign ld_addr_o   = ld_addr_q;
`endif

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

endmodule
